// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register,
// stall/redirect/halt control and a fetched-instruction counter.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic [31:0] pc_addr_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        halted_o,
  output logic [31:0] fetch_cnt_o
);

  localparam logic [31:0] MASK = 32'(IMEM_WORDS * 4 - 1);

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_seq;
  logic [31:0] pc_tgt;

  assign pc_seq = (pc_q + 32'd4) & MASK;
  assign pc_tgt = redirect_pc_i & MASK & ~32'd3;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (state_q == HALT) begin
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (halt_i) begin
      state_d = HALT;
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (redirect_i) begin
      // Redirect beats stall: the squashed fetch is wrong-path anyway.
      pc_d    = pc_tgt;
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      pc_d    = pc_seq;
      instr_d = instr_i;
      pc4_d   = pc_seq;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_addr_o    = pc_q;
  assign ifid_instr_o = instr_q;
  assign ifid_pc4_o   = pc4_q;
  assign ifid_valid_o = valid_q;
  assign halted_o     = (state_q == HALT);
  assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: driver queues expected
// post-edge state, monitor pops and compares on the falling edge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        stall;
  logic        redir;
  logic [31:0] rpc;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fcnt;

  logic [31:0] mem [0:127];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          drv_done = 1'b0;

  typedef struct {
    int          cyc;
    string       nm;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  assign instr = mem[pc[8:2]];

  if_fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .instr_i(instr),
    .stall_i(stall),
    .redirect_i(redir),
    .redirect_pc_i(rpc),
    .halt_i(halt),
    .pc_addr_o(pc),
    .ifid_instr_o(ifid_instr),
    .ifid_pc4_o(ifid_pc4),
    .ifid_valid_o(ifid_valid),
    .halted_o(halted),
    .fetch_cnt_o(fcnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, string f,
                     logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, f, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk(e.nm, "pc", pc, e.pc);
        chk(e.nm, "instr", ifid_instr, e.instr);
        chk(e.nm, "pc4", ifid_pc4, e.pc4);
        chk(e.nm, "valid", {31'b0, ifid_valid}, {31'b0, e.valid});
        chk(e.nm, "halted", {31'b0, halted}, {31'b0, e.halted});
        chk(e.nm, "cnt", fcnt, e.cnt);
      end
    end
  end

  task automatic step(string nm, logic r, logic s, logic d,
                      logic [31:0] t, logic h,
                      logic [31:0] epc, logic [31:0] ei,
                      logic [31:0] ep4, logic ev, logic eh,
                      logic [31:0] ec);
    exp_t e;
    rst = r; stall = s; redir = d; rpc = t; halt = h;
    e.cyc = cyc + 1; e.nm = nm; e.pc = epc; e.instr = ei;
    e.pc4 = ep4; e.valid = ev; e.halted = eh; e.cnt = ec;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    step("rst0", 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step("t1e1", 0, 0, 0, 0, 0, 32'h4, 32'h2008_0005, 32'h4, 1, 0, 1);
    step("t1e2", 0, 0, 0, 0, 0, 32'h8, 32'h2009_0003, 32'h8, 1, 0, 2);
    for (int i = 0; i < 3; i++)
      step("t2stl", 0, 1, 0, 0, 0, 32'h8, 32'h2009_0003, 32'h8, 1, 0, 2);
    step("t2rel", 0, 0, 0, 0, 0, 32'hC, 32'hA000_0002, 32'hC, 1, 0, 3);
    step("t2nxt", 0, 0, 0, 0, 0, 32'h10, 32'hA000_0003, 32'h10, 1, 0, 4);
    step("t3red", 0, 0, 1, 32'h40, 0, 32'h40, 32'h0, 32'h0, 0, 0, 4);
    step("t3nxt", 0, 0, 0, 0, 0, 32'h44, 32'hA000_0010, 32'h44, 1, 0, 5);
    step("t4sr", 0, 1, 1, 32'h20, 0, 32'h20, 32'h0, 32'h0, 0, 0, 5);
    step("t5red", 0, 0, 1, 32'h1FC, 0, 32'h1FC, 32'h0, 32'h0, 0, 0, 5);
    step("t5wrap", 0, 0, 0, 0, 0, 32'h0, 32'hA000_007F, 32'h0, 1, 0, 6);
    step("t5msk", 0, 0, 1, 32'h203, 0, 32'h0, 32'h0, 32'h0, 0, 0, 6);
    step("t5hi", 0, 0, 1, 32'hFFFF_FF48, 0, 32'h148, 32'h0, 32'h0, 0, 0, 6);
    step("t5hin", 0, 0, 0, 0, 0, 32'h14C, 32'hA000_0052, 32'h14C, 1, 0, 7);
    step("t6to24", 0, 0, 1, 32'h24, 0, 32'h24, 32'h0, 32'h0, 0, 0, 7);
    step("t6halt", 0, 0, 0, 0, 1, 32'h24, 32'h0, 32'h0, 0, 1, 7);
    for (int i = 0; i < 5; i++)
      step("t6hold", 0, 1'(i), 1, 32'h80, 1'(i >> 1),
           32'h24, 32'h0, 32'h0, 0, 1, 7);
    step("t6hseq", 0, 0, 0, 0, 0, 32'h24, 32'h0, 32'h0, 0, 1, 7);
    step("t6rst", 1, 0, 1, 32'h80, 1, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step("t6run", 0, 0, 0, 0, 0, 32'h4, 32'h2008_0005, 32'h4, 1, 0, 1);
    step("t6seq", 0, 0, 0, 0, 0, 32'h8, 32'h2009_0003, 32'h8, 1, 0, 2);
    step("rststl", 1, 1, 1, 32'h40, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step("rstres", 0, 0, 0, 0, 0, 32'h4, 32'h2008_0005, 32'h4, 1, 0, 1);
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    drv_done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    if (!drv_done) begin
      $display("FAIL timeout cyc=%0d want=finish", cyc);
      $fatal(1, "timeout");
    end
  end

endmodule
